// File: rtl/xor_stream_decoder.sv
// rtl/xor_stream_decoder.sv - XOR state-feedback stream decoder with word packing and output FIFO
module xor_stream_decoder #(
   parameter int   WORD_W     = 8,
   parameter int   FIFO_DEPTH = 4,
   parameter logic INIT_STATE = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_bit,
   output logic                      in_ready,
   input  logic                      resync,
   output logic                      out_valid,
   output logic [WORD_W-1:0]         out_word,
   input  logic                      out_ready,
   output logic [$clog2(WORD_W)-1:0] bit_cnt
);

   localparam int CW    = $clog2(WORD_W);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;

   logic              prev;
   logic [WORD_W-1:0] shift;
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              last_bit;
   logic              fifo_full;
   logic              acc;
   logic              dec;
   logic              push;
   logic              pop;
   logic [WORD_W-1:0] push_word;

   assign last_bit  = (bit_cnt == CW'(WORD_W - 1));
   assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
   // Only the final bit of a word can stall, and only on registered FIFO state.
   assign in_ready  = !resync && !(last_bit && fifo_full);
   assign acc       = in_valid && in_ready;
   assign dec       = in_bit ^ prev;
   assign push      = acc && last_bit;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push_word = {dec, shift[WORD_W-2:0]};
   assign out_word  = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev    <= INIT_STATE;
         bit_cnt <= '0;
         shift   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (resync) begin
            prev    <= INIT_STATE;
            bit_cnt <= '0;
            shift   <= '0;
         end else if (acc) begin
            prev <= in_bit;
            if (last_bit) begin
               bit_cnt <= '0;
               shift   <= '0;
            end else begin
               bit_cnt        <= bit_cnt + CW'(1);
               shift[bit_cnt] <= dec;
            end
         end

         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_stream_decoder.sv
// tb/tb_xor_stream_decoder.sv - scoreboard bench for xor_stream_decoder
module tb_xor_stream_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_ready;
   logic       resync = 1'b0;
   logic       out_valid;
   logic [7:0] out_word;
   logic       out_ready = 1'b0;
   logic [2:0] bit_cnt;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q [$];
   logic       tx_state = 1'b0;

   xor_stream_decoder #(.WORD_W(8), .FIFO_DEPTH(4), .INIT_STATE(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .resync    (resync),
      .out_valid (out_valid),
      .out_word  (out_word),
      .out_ready (out_ready),
      .bit_cnt   (bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops the scoreboard on every handshake the DUT will complete at the next edge.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", {24'd0, out_word}, 32'hFFFF_FFFF);
         end else begin
            check("word", {24'd0, out_word}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic send_enc(input logic e);
      int n = 0;
      in_valid = 1'b1;
      in_bit   = e;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) check("accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      tx_state = e;
      in_valid = 1'b0;
   endtask

   function automatic logic [7:0] enc_bits(input logic [7:0] d, input logic s0);
      logic [7:0] e;
      logic       s;
      s = s0;
      for (int i = 0; i < 8; i++) begin
         e[i] = d[i] ^ s;
         s    = e[i];
      end
      return e;
   endfunction

   task automatic send_word(input logic [7:0] d);
      logic [7:0] e;
      e = enc_bits(d, tx_state);
      exp_q.push_back(d);
      for (int i = 0; i < 8; i++) send_enc(e[i]);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      @(posedge clk);
      #1;
      check({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tx_state = 1'b0;
   endtask

   initial begin
      logic [7:0] vec;
      logic [7:0] e;
      vec = 8'b0110_0011;

      // Test 1: reset state, then known vector with exact latency.
      do_reset();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_word", {24'd0, out_word}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_bit_cnt", {29'd0, bit_cnt}, 32'd0);
      out_ready = 1'b1;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 7; i++) send_enc(vec[i]);
      in_valid = 1'b1;
      in_bit   = vec[7];
      check("t1_pre_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tx_state = vec[7];
      check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
      check("t1_latency_word", {24'd0, out_word}, 32'hA5);
      drain("t1");

      // Test 2: prev carries across word boundary.
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h00);
      for (int i = 0; i < 16; i++) send_enc(1'b1);
      drain("t2");

      // Test 3: backpressure fills FIFO, last bit of 5th word stalls.
      out_ready = 1'b0;
      send_word(8'hA5);
      send_word(8'h5A);
      send_word(8'hC3);
      send_word(8'h3C);
      e = enc_bits(8'h96, tx_state);
      exp_q.push_back(8'h96);
      for (int i = 0; i < 7; i++) send_enc(e[i]);
      in_valid = 1'b1;
      in_bit   = e[7];
      repeat (3) @(negedge clk);
      check("t3_stall_ready", {31'd0, in_ready}, 32'd0);
      check("t3_stall_cnt", {29'd0, bit_cnt}, 32'd7);
      check("t3_stall_word", {24'd0, out_word}, 32'hA5);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("t3_ready_after_pop", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tx_state = e[7];
      check("t3_accepted_cnt", {29'd0, bit_cnt}, 32'd0);
      check("t3_valid_held", {31'd0, out_valid}, 32'd1);
      check("t3_head_word", {24'd0, out_word}, 32'h5A);
      drain("t3");

      // Test 4: resync drops partial word and does not consume offered bit.
      send_enc(1'b1);
      send_enc(1'b0);
      send_enc(1'b1);
      resync   = 1'b1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(negedge clk);
      check("t4_resync_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      resync   = 1'b0;
      in_valid = 1'b0;
      tx_state = 1'b0;
      check("t4_resync_cnt", {29'd0, bit_cnt}, 32'd0);
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 8; i++) send_enc(vec[i]);
      drain("t4");

      // Test 5: reset mid-word with words queued.
      out_ready = 1'b0;
      send_word(8'h12);
      send_word(8'h34);
      for (int i = 0; i < 5; i++) send_enc(1'b1);
      check("t5_pre_cnt", {29'd0, bit_cnt}, 32'd5);
      check("t5_pre_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tx_state = 1'b0;
      exp_q.delete();
      check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
      check("t5_rst_cnt", {29'd0, bit_cnt}, 32'd0);
      check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
      check("t5_rst_word", {24'd0, out_word}, 32'd0);
      out_ready = 1'b1;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 8; i++) send_enc(vec[i]);
      drain("t5");

      // Test 6: simultaneous push and pop with one entry.
      out_ready = 1'b0;
      send_word(8'h11);
      e = enc_bits(8'h22, tx_state);
      exp_q.push_back(8'h22);
      for (int i = 0; i < 7; i++) send_enc(e[i]);
      in_valid  = 1'b1;
      in_bit    = e[7];
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tx_state  = e[7];
      check("t6_valid", {31'd0, out_valid}, 32'd1);
      check("t6_word", {24'd0, out_word}, 32'h22);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("t6_single_entry", {31'd0, out_valid}, 32'd0);
      check("t6_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

endmodule
